// File: rtl/gpr_file_scoreboard.sv
// gpr_file_scoreboard: 32x32 GPR file with per-register in-flight producer counters.
// Optional write-through bypass is enabled by defining GPR_BYPASS_EN.
module gpr_file_scoreboard #(
  parameter int MAX_INFLIGHT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic        rs_used,
  input  logic        rt_used,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        issue_valid,
  input  logic        issue_writes,
  input  logic [4:0]  issue_dest,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] pending_mask
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  logic [31:0]   regs [32];
  logic [CW-1:0] cnt  [32];

  logic        wb_hit;
  logic [31:0] arr_rs;
  logic [31:0] arr_rt;
  logic        cred_rs;
  logic        cred_rt;
  logic        haz_a;
  logic        haz_b;
  logic        full;
  logic        inc;
  logic [31:0] inc_v;
  logic [31:0] dec_v;

  assign wb_hit = wb_we & (wb_addr != 5'd0);
  assign arr_rs = (rs_addr == 5'd0) ? 32'd0 : regs[rs_addr];
  assign arr_rt = (rt_addr == 5'd0) ? 32'd0 : regs[rt_addr];

`ifdef GPR_BYPASS_EN
  // A final writeback landing this cycle satisfies a same-cycle read.
  assign cred_rs = wb_we & (wb_addr == rs_addr);
  assign cred_rt = wb_we & (wb_addr == rt_addr);
  assign rs_data = (wb_hit && wb_addr == rs_addr) ? wb_data : arr_rs;
  assign rt_data = (wb_hit && wb_addr == rt_addr) ? wb_data : arr_rt;
`else
  assign cred_rs = 1'b0;
  assign cred_rt = 1'b0;
  assign rs_data = arr_rs;
  assign rt_data = arr_rt;
`endif

  assign haz_a = rs_used & (rs_addr != 5'd0)
               & (cnt[rs_addr] > CW'(cred_rs));
  assign haz_b = rt_used & (rt_addr != 5'd0)
               & (cnt[rt_addr] > CW'(cred_rt));
  assign full  = issue_writes & (issue_dest != 5'd0)
               & (cnt[issue_dest] == CW'(MAX_INFLIGHT));
  assign stall = issue_valid & (haz_a | haz_b | full);

  assign inc   = issue_valid & issue_writes & ~stall
               & (issue_dest != 5'd0);
  assign inc_v = inc ? (32'd1 << issue_dest) : 32'd0;
  assign dec_v = wb_hit ? (32'd1 << wb_addr) : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 32; n++) regs[n] <= 32'd0;
    end else if (wb_hit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Flush wins over inc; decrement saturates so late writebacks are harmless.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 32; n++) cnt[n] <= '0;
    end else if (flush) begin
      for (int n = 0; n < 32; n++) cnt[n] <= '0;
    end else begin
      for (int n = 0; n < 32; n++) begin
        if (inc_v[n] && !dec_v[n])
          cnt[n] <= cnt[n] + CW'(1);
        else if (dec_v[n] && !inc_v[n] && cnt[n] != '0)
          cnt[n] <= cnt[n] - CW'(1);
      end
    end
  end

  always_comb begin
    pending_mask = 32'd0;
    for (int n = 0; n < 32; n++) pending_mask[n] = (cnt[n] != '0);
  end

endmodule

// File: tb/tb_gpr_file_scoreboard.sv
// Scoreboard bench for gpr_file_scoreboard: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_gpr_file_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rs_used;
  logic        rt_used;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        issue_valid;
  logic        issue_writes;
  logic [4:0]  issue_dest;
  logic        flush;
  logic        stall;
  logic [31:0] pending_mask;

  gpr_file_scoreboard #(.MAX_INFLIGHT(3)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_used(rs_used), .rt_used(rt_used),
    .rs_data(rs_data), .rt_data(rt_data),
    .issue_valid(issue_valid), .issue_writes(issue_writes),
    .issue_dest(issue_dest), .flush(flush),
    .stall(stall), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  localparam int K_RS = 0;
  localparam int K_RT = 1;
  localparam int K_ST = 2;
  localparam int K_PM = 3;

  typedef struct {
    string       nm;
    int          kind;
    logic [31:0] v;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic [31:0] act;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic exp_push(input string nm, input int kind,
                          input logic [31:0] v);
    exp_t x;
    x.nm = nm;
    x.kind = kind;
    x.v = v;
    q.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (q.size() != 0) begin
      e = q.pop_front();
      case (e.kind)
        K_RS:    act = rs_data;
        K_RT:    act = rt_data;
        K_ST:    act = {31'd0, stall};
        default: act = pending_mask;
      endcase
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    wb_we = 0; wb_addr = 0; wb_data = 0;
    rs_addr = 0; rt_addr = 0; rs_used = 0; rt_used = 0;
    issue_valid = 0; issue_writes = 0; issue_dest = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Load r5, issue a producer for r6
    cyc();
    wb_we = 1; wb_addr = 5; wb_data = 32'hAAAA5555;
    issue_valid = 1; issue_writes = 1; issue_dest = 6;
    exp_push("issue_r6_accepted", K_ST, 32'd0);
    cyc();
    wb_we = 0; issue_writes = 0;
    rs_addr = 5; rs_used = 1; rt_addr = 6; rt_used = 1;
    exp_push("read_r5", K_RS, 32'hAAAA5555);
    exp_push("read_r6_unwritten", K_RT, 32'd0);
    exp_push("pending_r6", K_PM, 32'h0000_0040);
    exp_push("stall_on_r6", K_ST, 32'd1);

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #2 reset = 1'b1;
    exp_push("rst_rs_data", K_RS, 32'd0);
    exp_push("rst_rt_data", K_RT, 32'd0);
    exp_push("rst_pending", K_PM, 32'd0);
    exp_push("rst_stall", K_ST, 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    cyc();
    issue_valid = 0; rs_used = 0; rt_used = 0;
    rs_addr = 5; rt_addr = 0;
    exp_push("r5_after_reset", K_RS, 32'd0);

    // Write r7, then read it
    cyc();
    wb_we = 1; wb_addr = 7; wb_data = 32'hDEADBEEF; rs_addr = 7;
`ifdef GPR_BYPASS_EN
    exp_push("r7_same_cycle", K_RS, 32'hDEADBEEF);
`else
    exp_push("r7_same_cycle", K_RS, 32'd0);
`endif
    cyc();
    wb_we = 0;
    exp_push("r7_next_cycle", K_RS, 32'hDEADBEEF);

    // r0 ignores writes
    cyc();
    wb_we = 1; wb_addr = 0; wb_data = 32'h12345678;
    rs_addr = 0; rt_addr = 0;
    exp_push("r0_during_write", K_RS, 32'd0);
    cyc();
    wb_we = 0;
    exp_push("r0_after_write", K_RT, 32'd0);

    // RAW hazard on r3
    cyc();
    issue_valid = 1; issue_writes = 1; issue_dest = 3;
    exp_push("issue_r3", K_ST, 32'd0);
    cyc();
    issue_writes = 0; rs_addr = 3; rs_used = 1;
    exp_push("pending_r3", K_PM, 32'h0000_0008);
    exp_push("raw_stall_c1", K_ST, 32'd1);
    cyc();
    exp_push("raw_stall_c2", K_ST, 32'd1);
    cyc();
    rs_used = 0; rt_used = 0; rt_addr = 3;
    exp_push("unused_ops_no_stall", K_ST, 32'd0);
    cyc();
    rs_used = 1; rt_addr = 0;
    wb_we = 1; wb_addr = 3; wb_data = 32'h55;
`ifdef GPR_BYPASS_EN
    exp_push("raw_wb_cycle_stall", K_ST, 32'd0);
    exp_push("raw_wb_cycle_data", K_RS, 32'h55);
`else
    exp_push("raw_wb_cycle_stall", K_ST, 32'd1);
    exp_push("raw_wb_cycle_data", K_RS, 32'd0);
`endif
    cyc();
    wb_we = 0;
    exp_push("raw_after_stall", K_ST, 32'd0);
    exp_push("raw_after_data", K_RS, 32'h55);
    exp_push("raw_after_pending", K_PM, 32'd0);

    // Multiple producers to r9
    cyc();
    rs_used = 0; rs_addr = 0;
    issue_writes = 1; issue_dest = 9;
    exp_push("r9_issue1", K_ST, 32'd0);
    cyc();
    exp_push("r9_issue2", K_ST, 32'd0);
    cyc();
    wb_we = 1; wb_addr = 9; wb_data = 32'h99;
    exp_push("r9_issue_wb_same", K_ST, 32'd0);
    cyc();
    wb_we = 0;
    exp_push("r9_issue3", K_ST, 32'd0);
    cyc();
    exp_push("r9_issue4_full", K_ST, 32'd1);
    cyc();
    issue_valid = 0; issue_writes = 0;
    wb_we = 1; wb_addr = 9;
    exp_push("r9_drain1", K_PM, 32'h0000_0200);
    cyc();
    exp_push("r9_drain2", K_PM, 32'h0000_0200);
    cyc();
    exp_push("r9_drain3", K_PM, 32'h0000_0200);
    cyc();
    wb_we = 0;
    exp_push("r9_drained", K_PM, 32'd0);

    // Flush with two producers on r4
    cyc();
    issue_valid = 1; issue_writes = 1; issue_dest = 4;
    cyc();
    cyc();
    issue_valid = 0; flush = 1;
    exp_push("r4_cnt2_pending", K_PM, 32'h0000_0010);
    cyc();
    flush = 0;
    exp_push("flush_clears", K_PM, 32'd0);
    wb_we = 1; wb_addr = 4; wb_data = 32'h44;
    cyc();
    wb_we = 0; rs_addr = 4;
    exp_push("wb_after_flush_pm", K_PM, 32'd0);
    exp_push("wb_after_flush_data", K_RS, 32'h44);

    // Issue in the flush cycle is dropped
    cyc();
    issue_valid = 1; issue_writes = 1; issue_dest = 4; flush = 1;
    exp_push("flush_issue_stall", K_ST, 32'd0);
    cyc();
    issue_valid = 0; issue_writes = 0; flush = 0;
    exp_push("flush_drops_inc", K_PM, 32'd0);

    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
